irq_handler: RTL and testbench
==============================

# irq_handler

Core-side interrupt handler and the consumer of the interrupt controller's `irq_o`/`irq_id_o` request. It gates requests with `mstatus.MIE` and takes an interrupt only at an instruction boundary. Trap entry stalls the pipeline, writes `mepc`, `mcause` and `mstatus` through the CSR write port one per cycle, then redirects fetch to the trap vector. It also sequences `mret` so that `mstatus` is restored and fetch is redirected to `mepc`.

## Interface
- Parameters: none.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `irq_i`  in  1  registered interrupt request from the interrupt controller.
- `irq_id_i`  in  8  interrupt number, valid with `irq_i`.
- `inst_valid_i`  in  1  a valid instruction occupies EX this cycle.
- `inst_addr_i`  in  32  PC of the instruction in EX (not yet committed).
- `busy_i`  in  1  EX is mid multi-cycle op or a jump is pending; no interrupt may be taken.
- `mret_i`  in  1  instruction in EX is `mret`.
- `mstatus_i`  in  32  current `mstatus`.
- `mtvec_i`  in  32  current `mtvec`.
- `mepc_i`  in  32  current `mepc`.
- `hold_o`  out  1  pipeline stall request.
- `csr_we_o`  out  1  CSR write strobe.
- `csr_waddr_o`  out  12  CSR address.
- `csr_wdata_o`  out  32  CSR write data.
- `int_assert_o`  out  1  one-cycle fetch redirect pulse.
- `int_addr_o`  out  32  redirect target, valid with `int_assert_o`.

## Operation
- **Take condition:** `take = irq_i & mstatus_i[3] & inst_valid_i & ~busy_i & (state==IDLE)`.
- **Mret condition:** `do_mret = mret_i & inst_valid_i & ~take & (state==IDLE)`.
  - If `take` and `do_mret` are both true, the interrupt wins.
  - In that case `mepc` = address of the `mret`, which re-executes after return.
- **Capture on take:** `id_q <= irq_id_i`, `pc_q <= inst_addr_i`, `mstatus_q <= mstatus_i`, `mtvec_q <= mtvec_i`.
- **Capture on mret:** `mstatus_q <= mstatus_i`, `mepc_q <= mepc_i`.
- **FSM states:**
  - `IDLE`: `take` goes to `SAVE_MEPC`; `do_mret` goes to `MRET_MSTATUS`; otherwise stay.
  - `SAVE_MEPC`: writes `0x341` with `pc_q`, goes to `SAVE_MCAUSE`.
  - `SAVE_MCAUSE`: writes `0x342` with `{1'b1, 23'h0, id_q}`, goes to `SAVE_MSTATUS`.
  - `SAVE_MSTATUS`: writes `0x300` with `mstatus_q`, where MPIE(bit 7) = old MIE(bit 3) and MIE = 0. Goes to `JUMP`.
  - `JUMP`: `int_assert_o = 1`, `int_addr_o` = vector address. Goes to `IDLE`.
  - `MRET_MSTATUS`: writes `0x300` with MIE = old MPIE and MPIE = 1. Goes to `MRET_JUMP`.
  - `MRET_JUMP`: `int_assert_o = 1`, `int_addr_o = mepc_q`. Goes to `IDLE`.
- **Vector address:** `{mtvec_q[31:2], 2'b00}`, or the vectored form (see Configuration).
- **`hold_o`:** `take | do_mret | (state != IDLE)`. It is combinational in the accept cycle, so the preempted instruction does not commit.
- **Sequence runs to completion:**
  - `irq_i` dropping or `irq_id_i` changing after accept has no effect; the captured values are used.
  - `mstatus_i`/`mtvec_i` changes during the sequence are ignored.
- **Outputs outside write/jump states:** `csr_we_o = 0` in non-write states. `csr_waddr_o`, `csr_wdata_o` and `int_addr_o` are 0 whenever their strobe is low.
- **No source clearing:** the handler does not clear the interrupt source; software clears the pending bit via write-1-clear.

## Timing
- **Reset values:** `state = IDLE`, all captured registers 0, all outputs 0.
- **Asynchronous reset mid-sequence:** returns to `IDLE` immediately; no further CSR writes or redirect.
- **Trap entry, accept at cycle T:**
  - T: `hold_o` = 1.
  - T+1: `mepc` write.
  - T+2: `mcause` write.
  - T+3: `mstatus` write.
  - T+4: redirect.
  - T+5: `IDLE`, `hold_o` = 0.
  - Total stall is 5 cycles.
- **`mret` accepted at T:**
  - T+1: `mstatus` write.
  - T+2: redirect.
  - `hold_o` is high for T..T+2.
- **Back-to-back:** a new `take` is evaluated in the first `IDLE` cycle after `JUMP`. It normally fails because MIE is now 0.
- **Masked requests:** `irq_i` while MIE = 0 or `busy_i` = 1 is ignored. It is taken in the first cycle the take condition holds.

## Configuration
- **Macro:** `IRQ_VECTORED_EN`.
- **Defined:** when `mtvec_q[1:0] == 2'b01`, the vector address is `{mtvec_q[31:2], 2'b00} + (id_q << 2)`, computed in 32 bits with wrap-around.
- **Undefined:** the vector address is always `{mtvec_q[31:2], 2'b00}` regardless of mode bits.

## Structure
- **Shared package (`defines.sv`):**
  - CSR address constants `CSR_MSTATUS`, `CSR_MEPC`, `CSR_MCAUSE`.
  - MIE/MPIE bit-index constants.
  - A `typedef enum logic [2:0]` for the seven FSM states.
- **Sub-modules:** none; a flat module. Captured registers use `gen_en_dff` with enable = `take` or `do_mret`.

## Test plan
- **Basic trap entry:** MIE = 1, `inst_valid_i` = 1, `inst_addr_i` = 0x100, `mtvec_i` = 0x200, `irq_i` = 1, id = 5.
  - Writes in order: `mepc` = 0x100, `mcause` = 0x80000005, `mstatus` with MIE = 0 / MPIE = 1.
  - Then `int_addr_o` = 0x200 at T+4; `hold_o` is high for 5 cycles.
- **Masked then unmasked:** MIE = 0 with `irq_i` = 1 produces no activity. Raise MIE while `busy_i` = 1: still nothing. Drop `busy_i`: accept in that cycle.
- **Mret:** `mret_i` with `mepc_i` = 0x1234 and `mstatus_i` MPIE = 1, MIE = 0.
  - `mstatus` is written with MIE = 1, MPIE = 1.
  - Redirect to 0x1234 at T+2.
- **Simultaneous events:** `irq_i` and `mret_i` in the same cycle at `inst_addr_i` = 0x80. Trap is taken, `mepc` = 0x80, and no `mstatus` restore occurs.
- **Reset mid-sequence:** deassert `rst_ni` in `SAVE_MCAUSE`. All outputs go to 0 immediately; after release, no `mstatus` write and no redirect.
- **`IRQ_VECTORED_EN` defined:** `mtvec_i` = 0x201, id = 3 gives `int_addr_o` = 0x20C. With the macro undefined, the same stimulus gives 0x200.

Source files
------------

// File: rtl/irq_handler_pkg.sv
// Shared CSR addresses, mstatus bit positions and FSM state encoding for the interrupt handler.
// Helpers build the mstatus images written on trap entry and on mret.
package irq_handler_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    typedef enum logic [2:0] {
        IDLE,
        SAVE_MEPC,
        SAVE_MCAUSE,
        SAVE_MSTATUS,
        JUMP,
        MRET_MSTATUS,
        MRET_JUMP
    } irq_state_e;

    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r                   = ms;
        r[MSTATUS_MPIE_BIT] = ms[MSTATUS_MIE_BIT];
        r[MSTATUS_MIE_BIT]  = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r                   = ms;
        r[MSTATUS_MIE_BIT]  = ms[MSTATUS_MPIE_BIT];
        r[MSTATUS_MPIE_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/irq_handler_en_dff.sv
// gen_en_dff: enable-loaded register with asynchronous active-low reset to zero.
// Latency: one cycle from en_i to q_o; no backpressure.
module gen_en_dff #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/irq_handler.sv
// Core interrupt handler: MIE-gated take at instruction boundary, trap entry (mepc/mcause/mstatus, then vector) and mret.
// Latency: trap stalls 5 cycles, mret 3; hold_o stalls EX combinationally on accept. IRQ_VECTORED_EN enables vectored mtvec.
module irq_handler
    import irq_handler_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irq_i,
    input  logic [7:0]  irq_id_i,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic        busy_i,
    input  logic        mret_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        hold_o,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    irq_state_e  state_q, state_d;
    logic        take, do_mret;
    logic [7:0]  id_q;
    logic [31:0] pc_q, mstatus_q, mtvec_q, mepc_q;
    logic [31:0] vec_base, vec_addr;

    assign take    = irq_i & mstatus_i[MSTATUS_MIE_BIT] & inst_valid_i & ~busy_i & (state_q == IDLE);
    assign do_mret = mret_i & inst_valid_i & ~take & (state_q == IDLE);
    assign hold_o  = take | do_mret | (state_q != IDLE);

    gen_en_dff #(.WIDTH(8))  u_id_q      (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(take),           .d_i(irq_id_i),    .q_o(id_q));
    gen_en_dff #(.WIDTH(32)) u_pc_q      (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(take),           .d_i(inst_addr_i), .q_o(pc_q));
    gen_en_dff #(.WIDTH(32)) u_mtvec_q   (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(take),           .d_i(mtvec_i),     .q_o(mtvec_q));
    gen_en_dff #(.WIDTH(32)) u_mstatus_q (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(take | do_mret), .d_i(mstatus_i),   .q_o(mstatus_q));
    gen_en_dff #(.WIDTH(32)) u_mepc_q    (.clk_i(clk_i), .rst_ni(rst_ni), .en_i(do_mret),        .d_i(mepc_i),      .q_o(mepc_q));

    assign vec_base = {mtvec_q[31:2], 2'b00};
`ifdef IRQ_VECTORED_EN
    assign vec_addr = (mtvec_q[1:0] == 2'b01) ? vec_base + ({24'h0, id_q} << 2) : vec_base;
`else
    // Mode bits are captured but only matter in the vectored build.
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_q[1:0];
    assign vec_addr          = vec_base;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = SAVE_MEPC;
                end else if (do_mret) begin
                    state_d = MRET_MSTATUS;
                end
            end
            SAVE_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = pc_q;
                state_d     = SAVE_MCAUSE;
            end
            SAVE_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = {1'b1, 23'h0, id_q};
                state_d     = SAVE_MSTATUS;
            end
            SAVE_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = trap_mstatus(mstatus_q);
                state_d     = JUMP;
            end
            JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = vec_addr;
                state_d      = IDLE;
            end
            MRET_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mret_mstatus(mstatus_q);
                state_d     = MRET_JUMP;
            end
            MRET_JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = mepc_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_irq_handler.sv
// Self-checking bench for irq_handler: per-cycle vector table through a scoreboard queue, plus reset corner cases.
module tb_irq_handler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        irq_i;
    logic [7:0]  irq_id_i;
    logic        inst_valid_i;
    logic [31:0] inst_addr_i;
    logic        busy_i;
    logic        mret_i;
    logic [31:0] mstatus_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        hold_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    always #5 clk_i = ~clk_i;

    irq_handler dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .irq_i(irq_i), .irq_id_i(irq_id_i),
        .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i), .busy_i(busy_i),
        .mret_i(mret_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .hold_o(hold_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    typedef struct packed {
        logic        hold;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        ia;
        logic [31:0] iaddr;
    } out_t;

    typedef struct {
        string       name;
        logic        irq;
        logic [7:0]  id;
        logic [31:0] ms;
        logic        valid;
        logic        busy;
        logic        mret;
        logic [31:0] addr;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        out_t        exp;
    } vec_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] MS_ON   = 32'h0000_1808;  // MPP=3, MIE=1, MPIE=0
    localparam logic [31:0] MS_OFF  = 32'h0000_1800;
    localparam logic [31:0] MS_TRAP = 32'h0000_1880;  // image after trap entry
    localparam logic [31:0] MS_MRET = 32'h0000_1888;  // image after mret from MS_TRAP
`ifdef IRQ_VECTORED_EN
    localparam logic [31:0] VEC_EXP = 32'h0000_020C;
`else
    localparam logic [31:0] VEC_EXP = 32'h0000_0200;
`endif

    function automatic out_t o(input logic h, input logic we, input logic [11:0] wa,
                               input logic [31:0] wd, input logic ia, input logic [31:0] ja);
        out_t r;
        r.hold = h; r.we = we; r.waddr = wa; r.wdata = wd; r.ia = ia; r.iaddr = ja;
        return r;
    endfunction

    function automatic void add(input string nm, input logic irq, input logic [7:0] id,
                                input logic [31:0] ms, input logic valid, input logic busy,
                                input logic mret, input logic [31:0] addr, input logic [31:0] mtvec,
                                input logic [31:0] mepc, input out_t exp);
        vec_t v;
        v.name = nm; v.irq = irq; v.id = id; v.ms = ms; v.valid = valid; v.busy = busy;
        v.mret = mret; v.addr = addr; v.mtvec = mtvec; v.mepc = mepc; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        irq_i = v.irq; irq_id_i = v.id; mstatus_i = v.ms; inst_valid_i = v.valid;
        busy_i = v.busy; mret_i = v.mret; inst_addr_i = v.addr; mtvec_i = v.mtvec; mepc_i = v.mepc;
    endtask

    task automatic expect_out(input string nm, input out_t e);
        sb_t s;
        s.name = nm; s.exp = e;
        sb_q.push_back(s);
    endtask

    task automatic check_out();
        sb_t  s;
        out_t act;
        act = {hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o};
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: output %h with no expectation", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL %s: hold/we/waddr/wdata/ia/iaddr got %b %b %h %h %b %h want %b %b %h %h %b %h",
                         s.name, act.hold, act.we, act.waddr, act.wdata, act.ia, act.iaddr,
                         s.exp.hold, s.exp.we, s.exp.waddr, s.exp.wdata, s.exp.ia, s.exp.iaddr);
            end
        end
    endtask

    task automatic idle_inputs();
        irq_i = 1'b0; irq_id_i = '0; mstatus_i = '0; inst_valid_i = 1'b0; busy_i = 1'b0;
        mret_i = 1'b0; inst_addr_i = '0; mtvec_i = '0; mepc_i = '0;
    endtask

    initial begin
        out_t z;
        z = o(0, 0, 12'h0, 32'h0, 0, 32'h0);

        // basic trap entry; irq/id/mstatus/mtvec change after accept and must be ignored
        add("idle",          0, 8'd0, MS_ON,  1, 0, 0, 32'hFC,  32'h200, 0, z);
        add("trap_accept",   1, 8'd5, MS_ON,  1, 0, 0, 32'h100, 32'h200, 0, o(1, 0, 12'h0,   32'h0, 0, 32'h0));
        add("trap_mepc",     0, 8'd9, 32'h0,  1, 0, 0, 32'h104, 32'h400, 0, o(1, 1, 12'h341, 32'h100, 0, 32'h0));
        add("trap_mcause",   0, 8'd9, 32'h0,  1, 0, 0, 32'h104, 32'h400, 0, o(1, 1, 12'h342, 32'h8000_0005, 0, 32'h0));
        add("trap_mstatus",  0, 8'd9, 32'h0,  1, 0, 0, 32'h104, 32'h400, 0, o(1, 1, 12'h300, MS_TRAP, 0, 32'h0));
        add("trap_jump",     0, 8'd9, 32'h0,  1, 0, 0, 32'h104, 32'h400, 0, o(1, 0, 12'h0,   32'h0, 1, 32'h200));
        add("b2b_mie_off",   1, 8'd5, MS_TRAP,1, 0, 0, 32'h200, 32'h200, 0, z);
        // masked, then unmasked while busy, then accepted when busy drops
        add("masked_mie0",   1, 8'd7, MS_OFF, 1, 0, 0, 32'h300, 32'h800, 0, z);
        add("masked_mie0_2", 1, 8'd7, MS_OFF, 1, 0, 0, 32'h300, 32'h800, 0, z);
        add("masked_noinst", 1, 8'd7, MS_ON,  0, 0, 0, 32'h300, 32'h800, 0, z);
        add("masked_busy",   1, 8'd7, MS_ON,  1, 1, 0, 32'h300, 32'h800, 0, z);
        add("unmask_accept", 1, 8'd7, MS_ON,  1, 0, 0, 32'h304, 32'h800, 0, o(1, 0, 12'h0,   32'h0, 0, 32'h0));
        add("unmask_mepc",   0, 8'd0, MS_ON,  1, 0, 0, 32'h308, 32'h800, 0, o(1, 1, 12'h341, 32'h304, 0, 32'h0));
        add("unmask_mcause", 0, 8'd0, MS_ON,  1, 0, 0, 32'h308, 32'h800, 0, o(1, 1, 12'h342, 32'h8000_0007, 0, 32'h0));
        add("unmask_mstat",  0, 8'd0, MS_ON,  1, 0, 0, 32'h308, 32'h800, 0, o(1, 1, 12'h300, MS_TRAP, 0, 32'h0));
        add("unmask_jump",   0, 8'd0, MS_ON,  1, 0, 0, 32'h308, 32'h800, 0, o(1, 0, 12'h0,   32'h0, 1, 32'h800));
        // mret
        add("mret_noinst",   0, 8'd0, MS_TRAP,0, 0, 1, 32'h50,  32'h0, 32'h1234, z);
        add("mret_accept",   0, 8'd0, MS_TRAP,1, 0, 1, 32'h50,  32'h0, 32'h1234, o(1, 0, 12'h0,   32'h0, 0, 32'h0));
        add("mret_mstatus",  0, 8'd0, 32'h0,  1, 0, 0, 32'h54,  32'h0, 32'h9999, o(1, 1, 12'h300, MS_MRET, 0, 32'h0));
        add("mret_jump",     0, 8'd0, 32'h0,  1, 0, 0, 32'h54,  32'h0, 32'h9999, o(1, 0, 12'h0,   32'h0, 1, 32'h1234));
        add("mret_done",     0, 8'd0, MS_MRET,1, 0, 0, 32'h1234,32'h0, 32'h0, z);
        // irq and mret together: trap wins, mepc is the mret's own address
        add("both_accept",   1, 8'd2, MS_ON,  1, 0, 1, 32'h80,  32'h200, 32'h4444, o(1, 0, 12'h0,   32'h0, 0, 32'h0));
        add("both_mepc",     0, 8'd0, MS_ON,  1, 0, 0, 32'h84,  32'h200, 32'h4444, o(1, 1, 12'h341, 32'h80, 0, 32'h0));
        add("both_mcause",   0, 8'd0, MS_ON,  1, 0, 0, 32'h84,  32'h200, 32'h4444, o(1, 1, 12'h342, 32'h8000_0002, 0, 32'h0));
        add("both_mstatus",  0, 8'd0, MS_ON,  1, 0, 0, 32'h84,  32'h200, 32'h4444, o(1, 1, 12'h300, MS_TRAP, 0, 32'h0));
        add("both_jump",     0, 8'd0, MS_ON,  1, 0, 0, 32'h84,  32'h200, 32'h4444, o(1, 0, 12'h0,   32'h0, 1, 32'h200));
        add("both_no_mret",  0, 8'd0, MS_TRAP,1, 0, 0, 32'h200, 32'h200, 32'h4444, z);
        // vectored mode bits
        add("vec_accept",    1, 8'd3, MS_ON,  1, 0, 0, 32'h900, 32'h201, 0, o(1, 0, 12'h0,   32'h0, 0, 32'h0));
        add("vec_mepc",      0, 8'd0, MS_ON,  1, 0, 0, 32'h904, 32'h201, 0, o(1, 1, 12'h341, 32'h900, 0, 32'h0));
        add("vec_mcause",    0, 8'd0, MS_ON,  1, 0, 0, 32'h904, 32'h201, 0, o(1, 1, 12'h342, 32'h8000_0003, 0, 32'h0));
        add("vec_mstatus",   0, 8'd0, MS_ON,  1, 0, 0, 32'h904, 32'h201, 0, o(1, 1, 12'h300, MS_TRAP, 0, 32'h0));
        add("vec_jump",      0, 8'd0, MS_ON,  1, 0, 0, 32'h904, 32'h201, 0, o(1, 0, 12'h0,   32'h0, 1, VEC_EXP));
        add("vec_done",      0, 8'd0, MS_TRAP,1, 0, 0, VEC_EXP, 32'h201, 0, z);

        // reset state
        rst_ni = 1'b0;
        idle_inputs();
        #12;
        expect_out("reset_outputs", z);
        check_out();
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        expect_out("after_release", z);
        check_out();

        foreach (vecs[i]) begin
            @(negedge clk_i);
            drive(vecs[i]);
            expect_out(vecs[i].name, vecs[i].exp);
            #1;
            check_out();
        end

        // asynchronous reset while in SAVE_MCAUSE
        @(negedge clk_i);
        irq_i = 1'b1; irq_id_i = 8'd4; mstatus_i = MS_ON; inst_valid_i = 1'b1;
        busy_i = 1'b0; mret_i = 1'b0; inst_addr_i = 32'h600; mtvec_i = 32'h700;
        expect_out("rst_seq_accept", o(1, 0, 12'h0, 32'h0, 0, 32'h0));
        #1; check_out();
        @(negedge clk_i);
        irq_i = 1'b0;
        expect_out("rst_seq_mepc", o(1, 1, 12'h341, 32'h600, 0, 32'h0));
        #1; check_out();
        @(negedge clk_i);
        expect_out("rst_seq_mcause", o(1, 1, 12'h342, 32'h8000_0004, 0, 32'h0));
        #1; check_out();
        #1 rst_ni = 1'b0;
        #1;
        expect_out("rst_mid_outputs", z);
        check_out();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            expect_out("rst_no_resume", z);
            #1; check_out();
            @(negedge clk_i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
